fir_call_sequencer: RTL and testbench

// - Top-level ap_ctrl_hs controller for one fir call: latches sample x, runs the TDL pipelined loop, then the MAC pipelined loop.
// - Drives y from the MAC accumulator; asserts ap_done/ap_ready.
// - Multiplexes the single shift_reg memory port to whichever child loop owns the current phase.
// - Records the cycle count of the last call for the profiling flow.

---
 rtl/fir_call_sequencer_if.sv | 64 ++++++
 rtl/fir_call_sequencer.sv | 138 +++++++++++++
 tb/tb_fir_call_sequencer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_call_sequencer_if.sv
// Bundle of the fir call controller ports: host ap_ctrl_hs side,
// child loop handshakes and the shared shift_reg memory port.
interface fir_call_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 32
);
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic [DATA_W-1:0] x;
    logic [ACC_W-1:0]  y;
    logic              y_ap_vld;

    logic              tdl_start;
    logic              tdl_ready;
    logic              tdl_done;
    logic [DATA_W-1:0] tdl_x;

    logic              mac_start;
    logic              mac_ready;
    logic              mac_done;
    logic [ACC_W-1:0]  mac_acc;

    logic              tdl_sr_ce;
    logic              tdl_sr_we;
    logic [ADDR_W-1:0] tdl_sr_addr;
    logic [DATA_W-1:0] tdl_sr_d;
    logic              mac_sr_ce;
    logic [ADDR_W-1:0] mac_sr_addr;

    logic              sr_ce;
    logic              sr_we;
    logic [ADDR_W-1:0] sr_addr;
    logic [DATA_W-1:0] sr_d;

    logic [CNT_W-1:0]  call_cycles;

    modport slave (
        input  ap_start, x,
        input  tdl_ready, tdl_done,
        input  mac_ready, mac_done, mac_acc,
        input  tdl_sr_ce, tdl_sr_we, tdl_sr_addr, tdl_sr_d,
        input  mac_sr_ce, mac_sr_addr,
        output ap_done, ap_idle, ap_ready, y, y_ap_vld,
        output tdl_start, tdl_x, mac_start,
        output sr_ce, sr_we, sr_addr, sr_d,
        output call_cycles
    );

    modport master (
        output ap_start, x,
        output tdl_ready, tdl_done,
        output mac_ready, mac_done, mac_acc,
        output tdl_sr_ce, tdl_sr_we, tdl_sr_addr, tdl_sr_d,
        output mac_sr_ce, mac_sr_addr,
        input  ap_done, ap_idle, ap_ready, y, y_ap_vld,
        input  tdl_start, tdl_x, mac_start,
        input  sr_ce, sr_we, sr_addr, sr_d,
        input  call_cycles
    );
endinterface

// File: rtl/fir_call_sequencer.sv
// ap_ctrl_hs controller for one fir call: TDL loop, then MAC loop,
// with the shift_reg port handed to whichever loop owns the phase.
module fir_call_sequencer #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 32
) (
    input logic                 ap_clk,
    input logic                 ap_rst,
    fir_call_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_TDL_START,
        S_TDL_WAIT,
        S_MAC_START,
        S_MAC_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_ap_done;
    logic              r_ap_idle;
    logic              r_tdl_start;
    logic              r_mac_start;
    logic [DATA_W-1:0] r_tdl_x;
    logic [ACC_W-1:0]  r_y;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_call_cycles;

    logic              w_accept;
    logic              w_mac_fin;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_tdl_own;
    logic              w_mac_own;
    logic              w_sr_ce;
    logic              w_sr_we;
    logic [ADDR_W-1:0] w_sr_addr;
    logic [DATA_W-1:0] w_sr_d;

    assign w_accept  = bus.ap_start
                    && (r_state == S_IDLE || r_state == S_DONE);
    assign w_mac_fin = bus.mac_done
                    && (r_state == S_MAC_START || r_state == S_MAC_WAIT);
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    // A done without ready in a start state counts as ready+done.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.ap_start) w_next = S_TDL_START;
            end
            S_TDL_START: begin
                if (bus.tdl_done)       w_next = S_MAC_START;
                else if (bus.tdl_ready) w_next = S_TDL_WAIT;
            end
            S_TDL_WAIT: begin
                if (bus.tdl_done) w_next = S_MAC_START;
            end
            S_MAC_START: begin
                if (bus.mac_done)       w_next = S_DONE;
                else if (bus.mac_ready) w_next = S_MAC_WAIT;
            end
            S_MAC_WAIT: begin
                if (bus.mac_done) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = bus.ap_start ? S_TDL_START : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state       <= S_IDLE;
            r_ap_done     <= 1'b0;
            r_ap_idle     <= 1'b1;
            r_tdl_start   <= 1'b0;
            r_mac_start   <= 1'b0;
            r_tdl_x       <= '0;
            r_y           <= '0;
            r_cnt         <= '0;
            r_call_cycles <= '0;
        end else begin
            r_state     <= w_next;
            r_ap_done   <= (w_next == S_DONE);
            r_ap_idle   <= (w_next == S_IDLE);
            r_tdl_start <= (w_next == S_TDL_START);
            r_mac_start <= (w_next == S_MAC_START);
            if (w_accept) r_tdl_x <= bus.x;
            if (w_mac_fin) r_y <= bus.mac_acc;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= w_cnt_inc;
            end
            // The DONE cycle itself is part of the reported count.
            if (r_state == S_DONE) r_call_cycles <= w_cnt_inc;
        end
    end

    assign w_tdl_own = (r_state == S_TDL_START || r_state == S_TDL_WAIT);
    assign w_mac_own = (r_state == S_MAC_START || r_state == S_MAC_WAIT);

    always_comb begin
        w_sr_ce   = 1'b0;
        w_sr_we   = 1'b0;
        w_sr_addr = '0;
        w_sr_d    = '0;
        if (w_tdl_own) begin
            w_sr_ce   = bus.tdl_sr_ce;
            w_sr_we   = bus.tdl_sr_we;
            w_sr_addr = bus.tdl_sr_addr;
            w_sr_d    = bus.tdl_sr_d;
        end else if (w_mac_own) begin
            w_sr_ce   = bus.mac_sr_ce;
            w_sr_addr = bus.mac_sr_addr;
        end
    end

    assign bus.ap_done     = r_ap_done;
    assign bus.ap_ready    = r_ap_done;
    assign bus.y_ap_vld    = r_ap_done;
    assign bus.ap_idle     = r_ap_idle;
    assign bus.tdl_start   = r_tdl_start;
    assign bus.mac_start   = r_mac_start;
    assign bus.tdl_x       = r_tdl_x;
    assign bus.y           = r_y;
    assign bus.call_cycles = r_call_cycles;
    assign bus.sr_ce       = w_sr_ce;
    assign bus.sr_we       = w_sr_we;
    assign bus.sr_addr     = w_sr_addr;
    assign bus.sr_d        = w_sr_d;
endmodule

// File: tb/tb_fir_call_sequencer.sv
// Scoreboard bench for fir_call_sequencer with behavioural TDL/MAC
// loop models whose phase length (cycles incl. start) is programmable.
module tb_fir_call_sequencer;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_call_sequencer_if #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) bus ();

    fir_call_sequencer #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .ap_clk(clk),
        .ap_rst(rst),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          tdl_lat = 1;
    int          mac_lat = 1;
    logic [31:0] mac_val = '0;
    int          tdl_cnt = 0;
    int          mac_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_cyc = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // TDL loop model: ready in its first cycle, done in cycle tdl_lat.
    always @(negedge clk) begin
        bus.tdl_ready = 1'b0;
        bus.tdl_done  = 1'b0;
        if (rst) begin
            tdl_cnt = 0;
        end else if (bus.tdl_start || tdl_cnt > 0) begin
            tdl_cnt++;
            if (tdl_cnt == 1) bus.tdl_ready = 1'b1;
            if (tdl_cnt >= tdl_lat) begin
                bus.tdl_done = 1'b1;
                tdl_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        bus.mac_ready = 1'b0;
        bus.mac_done  = 1'b0;
        bus.mac_acc   = '0;
        if (rst) begin
            mac_cnt = 0;
        end else if (bus.mac_start || mac_cnt > 0) begin
            mac_cnt++;
            if (mac_cnt == 1) bus.mac_ready = 1'b1;
            if (mac_cnt >= mac_lat) begin
                bus.mac_done = 1'b1;
                bus.mac_acc  = mac_val;
                mac_cnt = 0;
            end
        end
    end

    // Monitor: every ap_done pops one expected call.
    always @(negedge clk) begin
        if (pend) begin
            chk("call_cycles", bus.call_cycles, pend_cyc);
            chk("vld_pulse_len", bus.y_ap_vld, 1'b0);
            pend = 1'b0;
        end
        if (!rst && bus.ap_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: ap_done=1 with no call pending");
            end else begin
                mon_e = sb.pop_front();
                chk("y", bus.y, mon_e.y);
                chk("y_ap_vld", bus.y_ap_vld, 1'b1);
                chk("ap_ready", bus.ap_ready, 1'b1);
                chk("idle_in_done", bus.ap_idle, 1'b0);
                chk("tdl_x_call", bus.tdl_x, mon_e.x);
                pend     = 1'b1;
                pend_cyc = mon_e.cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return bus.tdl_start;
            1:       return bus.mac_start;
            2:       return bus.ap_done;
            default: return bus.ap_idle;
        endcase
    endfunction

    task automatic wait_for(input int w, input string name);
        for (int i = 0; i < 200; i++) begin
            if (sig(w)) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL timeout_%s: got 0 expected 1 within 200 cycles", name);
    endtask

    initial begin
        bus.ap_start    = 1'b0;
        bus.x           = '0;
        bus.tdl_sr_ce   = 1'b0;
        bus.tdl_sr_we   = 1'b0;
        bus.tdl_sr_addr = '0;
        bus.tdl_sr_d    = '0;
        bus.mac_sr_ce   = 1'b0;
        bus.mac_sr_addr = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();

        chk("rst_idle", bus.ap_idle, 1'b1);
        chk("rst_done", bus.ap_done, 1'b0);
        chk("rst_ready", bus.ap_ready, 1'b0);
        chk("rst_vld", bus.y_ap_vld, 1'b0);
        chk("rst_tdl_start", bus.tdl_start, 1'b0);
        chk("rst_mac_start", bus.mac_start, 1'b0);
        chk("rst_sr_ce", bus.sr_ce, 1'b0);
        chk("rst_y", bus.y, 32'h0);
        chk("rst_cycles", bus.call_cycles, 32'h0);
        chk("rst_tdl_x", bus.tdl_x, 32'h0);

        // Abort in MAC_WAIT: no ap_done, y stays at its prior value 0.
        tdl_lat = 1;
        mac_lat = 30;
        mac_val = 32'hDEAD;
        bus.x = 32'h55;
        bus.ap_start = 1'b1;
        tick();
        bus.ap_start = 1'b0;
        wait_for(1, "abort_mac_start");
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("abort_idle", bus.ap_idle, 1'b1);
        chk("abort_mac_start", bus.mac_start, 1'b0);
        chk("abort_done", bus.ap_done, 1'b0);
        chk("abort_y", bus.y, 32'h0);
        rst = 1'b0;
        repeat (3) tick();
        chk("abort_stay_idle", bus.ap_idle, 1'b1);

        // Call: TDL phase 4 cycles, MAC phase 12 -> 4+12+1 = 17.
        tdl_lat = 4;
        mac_lat = 12;
        mac_val = 32'h123;
        bus.x = 32'd7;
        sb.push_back('{x: 32'd7, y: 32'h123, cyc: 32'd17});
        bus.ap_start = 1'b1;
        tick();
        bus.ap_start = 1'b0;
        bus.x = 32'h0;
        chk("c1_tdl_start", bus.tdl_start, 1'b1);
        chk("c1_tdl_x", bus.tdl_x, 32'd7);
        tick();
        chk("c1_tdl_start_drop", bus.tdl_start, 1'b0);
        bus.mac_sr_ce   = 1'b1;
        bus.mac_sr_addr = 4'd9;
        bus.tdl_sr_addr = 4'd3;
        #1;
        chk("tdl_ph_ce_blk", bus.sr_ce, 1'b0);
        chk("tdl_ph_addr", bus.sr_addr, 4'd3);
        bus.tdl_sr_ce = 1'b1;
        bus.tdl_sr_we = 1'b1;
        bus.tdl_sr_d  = 32'hAA;
        #1;
        chk("tdl_ph_ce", bus.sr_ce, 1'b1);
        chk("tdl_ph_we", bus.sr_we, 1'b1);
        chk("tdl_ph_d", bus.sr_d, 32'hAA);
        wait_for(1, "c1_mac_start");
        bus.mac_sr_ce = 1'b0;
        #1;
        chk("mac_ph_ce_blk", bus.sr_ce, 1'b0);
        chk("mac_ph_we", bus.sr_we, 1'b0);
        chk("mac_ph_d", bus.sr_d, 32'h0);
        chk("mac_ph_addr", bus.sr_addr, 4'd9);
        bus.mac_sr_ce = 1'b1;
        #1;
        chk("mac_ph_ce", bus.sr_ce, 1'b1);
        wait_for(3, "c1_idle");
        chk("idle_sr_ce", bus.sr_ce, 1'b0);
        chk("idle_sr_we", bus.sr_we, 1'b0);
        chk("idle_sr_addr", bus.sr_addr, 4'd0);
        bus.tdl_sr_ce = 1'b0;
        bus.tdl_sr_we = 1'b0;
        bus.mac_sr_ce = 1'b0;
        tick();

        // Children finish in their start cycles -> 3 cycles.
        tdl_lat = 1;
        mac_lat = 1;
        mac_val = 32'hCAFE0001;
        bus.x = 32'h11;
        sb.push_back('{x: 32'h11, y: 32'hCAFE0001, cyc: 32'd3});
        bus.ap_start = 1'b1;
        tick();
        bus.ap_start = 1'b0;
        chk("c2_tdl_start", bus.tdl_start, 1'b1);
        tick();
        chk("c2_mac_start", bus.mac_start, 1'b1);
        tick();
        chk("c2_done", bus.ap_done, 1'b1);
        tick();
        chk("c2_idle", bus.ap_idle, 1'b1);
        tick();

        // Back-to-back: ap_start held through DONE; 2+3+1 = 6 each.
        tdl_lat = 2;
        mac_lat = 3;
        mac_val = 32'hA5A5;
        bus.x = 32'h21;
        sb.push_back('{x: 32'h21, y: 32'hA5A5, cyc: 32'd6});
        sb.push_back('{x: 32'h22, y: 32'h5A5A, cyc: 32'd6});
        bus.ap_start = 1'b1;
        tick();
        bus.x = 32'h22;
        wait_for(2, "c3_done");
        mac_val = 32'h5A5A;
        tick();
        bus.ap_start = 1'b0;
        chk("b2b_tdl_start", bus.tdl_start, 1'b1);
        chk("b2b_no_idle", bus.ap_idle, 1'b0);
        chk("b2b_tdl_x", bus.tdl_x, 32'h22);
        wait_for(3, "c4_idle");

        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
